flowmap_depth_labeler: RTL and testbench

//  Streaming depth labeler: receives netlist nodes in topological order and

---
 rtl/flowmap_depth_labeler_if.sv | 31 +++
 rtl/flowmap_depth_labeler.sv | 160 ++++++++++++++++
 tb/tb_flowmap_depth_labeler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/flowmap_depth_labeler_if.sv
// Descriptor/result handshake bundle for the FlowMap depth labeler.
// The master side produces node descriptors and consumes labels.
// The slave side is the labeler itself.
interface flowmap_depth_labeler_if #(
   parameter int ID_W  = 4,
   parameter int LVL_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_kind;
   logic [ID_W-1:0]  in_id;
   logic [ID_W-1:0]  in_fi0;
   logic [ID_W-1:0]  in_fi1;
   logic [LVL_W-1:0] in_level;
   logic             out_valid;
   logic             out_ready;
   logic [ID_W-1:0]  out_id;
   logic [LVL_W-1:0] out_level;
   logic             out_err;
   logic             out_sat;

   modport master (
      output in_valid, in_kind, in_id, in_fi0, in_fi1, in_level, out_ready,
      input  in_ready, out_valid, out_id, out_level, out_err, out_sat
   );

   modport slave (
      input  in_valid, in_kind, in_id, in_fi0, in_fi1, in_level, out_ready,
      output in_ready, out_valid, out_id, out_level, out_err, out_sat
   );
endinterface

// File: rtl/flowmap_depth_labeler.sv
// Streaming depth labeler. Nodes arrive in topological order. A gate's level
// is max(fanin levels)+1 and saturates at 2**LVL_W-1. A primary input
// carries its own level. The table keeps one valid bit and one level per id.
// Only the valid bits are reset or cleared.
module flowmap_depth_labeler #(
   parameter int ID_W  = 4,
   parameter int LVL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   flowmap_depth_labeler_if.slave  bus
);
   localparam int DEPTH = 1 << ID_W;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;
   localparam logic [LVL_W:0] LVL_MAX = {1'b0, {LVL_W{1'b1}}};
   localparam logic [LVL_W:0] ONE_W   = {{LVL_W{1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic             idle_q;
   logic             in_ready_s;
   logic             accept_s;
   logic [1:0]       kind_q;
   logic [ID_W-1:0]  id_q, fi0_q, fi1_q;
   logic [LVL_W-1:0] lvin_q;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [LVL_W-1:0] lvl_q [DEPTH];
   logic             v0_s, v1_s;
   logic [LVL_W-1:0] l0_s, l1_s, mx_s;
   logic [LVL_W:0]   sum_s;
   logic [LVL_W-1:0] res_s;
   logic             err_s, sat_s, wr_s;
   logic             out_valid_q;
   logic [ID_W-1:0]  out_id_q;
   logic [LVL_W-1:0] out_level_q;
   logic             out_err_q, out_sat_q;

   // clear blocks acceptance; idle_q keeps in_ready low through reset
   assign in_ready_s    = idle_q & ~clear;
   assign accept_s      = bus.in_valid & in_ready_s;
   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_level = out_level_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_sat   = out_sat_q;

   // Level computation from the latched descriptor (reads the pre-write table)
   always_comb begin
      v0_s  = valid_q[fi0_q];
      v1_s  = valid_q[fi1_q];
      l0_s  = v0_s ? lvl_q[fi0_q] : {LVL_W{1'b0}};
      l1_s  = v1_s ? lvl_q[fi1_q] : {LVL_W{1'b0}};
      mx_s  = (l1_s > l0_s) ? l1_s : l0_s;
      sum_s = {(LVL_W+1){1'b0}};
      res_s = {LVL_W{1'b0}};
      err_s = 1'b0;
      sat_s = 1'b0;
      wr_s  = 1'b0;
      case (kind_q)
         2'b00: begin
            res_s = lvin_q;
            wr_s  = 1'b1;
         end
         2'b01: begin
            sum_s = {1'b0, l0_s} + ONE_W;
            err_s = ~v0_s;
            wr_s  = 1'b1;
         end
         2'b10: begin
            sum_s = {1'b0, mx_s} + ONE_W;
            err_s = ~v0_s | ~v1_s;
            wr_s  = 1'b1;
         end
         default: begin
            err_s = 1'b1;
         end
      endcase
      if (kind_q == 2'b01 || kind_q == 2'b10) begin
         if (sum_s > LVL_MAX) begin
            res_s = LVL_MAX[LVL_W-1:0];
            sat_s = 1'b1;
         end else begin
            res_s = sum_s[LVL_W-1:0];
         end
      end else begin
         sat_s = 1'b0;
      end
   end

   // FSM next state: IDLE -> CALC on accept, CALC -> OUT, OUT -> IDLE on handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_CALC;
            else          state_d = S_IDLE;
         end
         S_CALC: state_d = S_OUT;
         S_OUT: begin
            if (bus.out_ready) state_d = S_IDLE;
            else               state_d = S_OUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Valid-bit next state: clear wipes everything, the in-flight write still lands
   always_comb begin
      valid_d = valid_q;
      if (clear) valid_d = {DEPTH{1'b0}};
      else       valid_d = valid_q;
      if (state_q == S_CALC && wr_s) valid_d[id_q] = 1'b1;
      else                            valid_d = valid_d;
   end

   // FSM, valid bits, latched descriptor and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idle_q      <= 1'b0;
         valid_q     <= {DEPTH{1'b0}};
         kind_q      <= 2'b00;
         id_q        <= {ID_W{1'b0}};
         fi0_q       <= {ID_W{1'b0}};
         fi1_q       <= {ID_W{1'b0}};
         lvin_q      <= {LVL_W{1'b0}};
         out_valid_q <= 1'b0;
         out_id_q    <= {ID_W{1'b0}};
         out_level_q <= {LVL_W{1'b0}};
         out_err_q   <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_q      <= (state_d == S_IDLE);
         valid_q     <= valid_d;
         out_valid_q <= (state_d == S_OUT);
         if (state_q == S_IDLE && accept_s) begin
            kind_q <= bus.in_kind;
            id_q   <= bus.in_id;
            fi0_q  <= bus.in_fi0;
            fi1_q  <= bus.in_fi1;
            lvin_q <= bus.in_level;
         end
         if (state_q == S_CALC) begin
            out_id_q    <= id_q;
            out_level_q <= res_s;
            out_err_q   <= err_s;
            out_sat_q   <= sat_s;
         end
      end
   end

   // Level storage: contents are never reset, only qualified by valid_q
   always_ff @(posedge clk) begin
      if (state_q == S_CALC && wr_s) lvl_q[id_q] <= res_s;
   end
endmodule

// File: tb/tb_flowmap_depth_labeler.sv
// Directed bench for flowmap_depth_labeler with a table-level reference model.
module tb_flowmap_depth_labeler;
   localparam int ID_W   = 4;
   localparam int LVL_W  = 4;
   localparam int MAXLVL = (1 << LVL_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   flowmap_depth_labeler_if #(.ID_W(ID_W), .LVL_W(LVL_W)) bus ();
   flowmap_depth_labeler #(.ID_W(ID_W), .LVL_W(LVL_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   bit mvalid [16];
   int mlvl   [16];
   bit exp_pending = 1'b0;
   int exp_id = 0, exp_lvl = 0;
   bit exp_err = 1'b0, exp_sat = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
   endtask

   // Reference: level from the node rules, updating the model table
   task automatic model(input int kind, input int id, input int f0, input int f1,
                        input int lv, output int el, output bit ee, output bit es);
      int l0, l1, s;
      ee = 1'b0; es = 1'b0; el = 0; s = 0;
      l0 = mvalid[f0] ? mlvl[f0] : 0;
      l1 = mvalid[f1] ? mlvl[f1] : 0;
      case (kind)
         0: el = lv;
         1: begin s = l0 + 1; ee = !mvalid[f0]; end
         2: begin s = ((l0 > l1) ? l0 : l1) + 1; ee = !mvalid[f0] || !mvalid[f1]; end
         default: begin el = 0; ee = 1'b1; end
      endcase
      if (kind == 1 || kind == 2) begin
         if (s > MAXLVL) begin el = MAXLVL; es = 1'b1; end
         else el = s;
      end
      if (kind != 3) begin mvalid[id] = 1'b1; mlvl[id] = el; end
   endtask

   // Compare process: every cycle a result is shown it must match the model
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         check("spurious_out_valid", int'(bus.out_valid), int'(exp_pending));
         if (exp_pending) begin
            check("out_id", int'(bus.out_id), exp_id);
            check("out_level", int'(bus.out_level), exp_lvl);
            check("out_err", int'(bus.out_err), int'(exp_err));
            check("out_sat", int'(bus.out_sat), int'(exp_sat));
         end
      end
   end

   task automatic issue(input int kind, input int id, input int f0, input int f1,
                        input int lv, output int el);
      int n;
      bit ee, es;
      @(negedge clk);
      bus.in_kind  = kind[1:0];
      bus.in_id    = id[ID_W-1:0];
      bus.in_fi0   = f0[ID_W-1:0];
      bus.in_fi1   = f1[ID_W-1:0];
      bus.in_level = lv[LVL_W-1:0];
      bus.in_valid = 1'b1;
      #1;
      n = 0;
      while (!bus.in_ready && n < 50) begin @(negedge clk); #1; n++; end
      if (!bus.in_ready) check("accept_timeout", int'(bus.in_ready), 1);
      model(kind, id, f0, f1, lv, el, ee, es);
      exp_id = id; exp_lvl = el; exp_err = ee; exp_sat = es; exp_pending = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic collect();
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
      check("out_valid_arrives", int'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_pending = 1'b0;
      check("out_valid_drops_after_hs", int'(bus.out_valid), 0);
   endtask

   task automatic node(input int kind, input int id, input int f0, input int f1,
                       input int lv, output int el);
      issue(kind, id, f0, f1, lv, el);
      collect();
   endtask

   int el;
   int nl_kind [12] = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 2};
   int nl_f0   [12] = '{0, 0, 0, 0, 0, 0, 0, 6, 7, 4, 8, 10};
   int nl_f1   [12] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 7, 9, 5};
   int nl_lv   [12] = '{1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0};
   int nl_exp  [12] = '{1, 1, 2, 1, 3, 1, 2, 3, 4, 4, 5, 6};

   initial begin
      bus.in_valid = 1'b0; bus.in_kind = 2'b00; bus.in_id = 4'd0;
      bus.in_fi0 = 4'd0; bus.in_fi1 = 4'd0; bus.in_level = 4'd0;
      bus.out_ready = 1'b0;
      model_clear();
      for (int i = 0; i < 16; i++) mlvl[i] = 0;

      // reset state
      #12;
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_id", int'(bus.out_id), 0);
      check("rst_out_level", int'(bus.out_level), 0);
      check("rst_out_err", int'(bus.out_err), 0);
      check("rst_out_sat", int'(bus.out_sat), 0);
      @(negedge clk); rst_n = 1'b1;

      // 1: figure-4(a) netlist, ids 0..11 in topological order
      for (int i = 0; i < 12; i++) begin
         node(nl_kind[i], i, nl_f0[i], nl_f1[i], nl_lv[i], el);
         check("pin_netlist_level", el, nl_exp[i]);
      end

      // 2: undefined fanin still produces a level and an error
      node(2, 6, 12, 0, 0, el);
      check("pin_undef_level", el, 2);
      check("pin_undef_err", int'(exp_err), 1);

      // reserved kind does not write; self-reference reads the old entry
      node(3, 12, 0, 0, 0, el);
      node(1, 14, 12, 0, 0, el);
      check("pin_reserved_nowrite_err", int'(exp_err), 1);
      node(1, 13, 13, 0, 0, el);
      check("pin_selfref_err", int'(exp_err), 1);
      node(1, 13, 13, 0, 0, el);
      check("pin_selfref_redef", el, 2);

      // 3: saturation through 1-input and 2-input gates
      node(0, 0, 0, 0, 15, el);
      node(1, 1, 0, 0, 0, el);
      check("pin_sat_level", el, 15);
      check("pin_sat_flag", int'(exp_sat), 1);
      node(2, 2, 0, 1, 0, el);

      // 4: back-pressure for 5 cycles with a competing descriptor
      issue(0, 14, 0, 0, 7, el);
      for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         bus.in_kind = 2'b00; bus.in_id = 4'd15; bus.in_level = 4'd9; bus.in_valid = 1'b1;
         @(negedge clk);
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_out_valid", int'(bus.out_valid), 1);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_pending = 1'b0;
      check("stall_release_out_valid", int'(bus.out_valid), 0);
      check("stall_release_idle", int'(bus.in_ready), 1);
      repeat (4) @(negedge clk);
      node(1, 15, 14, 0, 0, el);

      // 5: clear wipes the table; clear with in_valid does not accept
      node(0, 3, 0, 0, 2, el);
      @(negedge clk); clear = 1'b1; model_clear();
      @(negedge clk); clear = 1'b0;
      node(1, 4, 3, 0, 0, el);
      check("pin_clear_level", el, 1);
      check("pin_clear_err", int'(exp_err), 1);
      @(negedge clk);
      clear = 1'b1; bus.in_kind = 2'b00; bus.in_id = 4'd2; bus.in_level = 4'd9; bus.in_valid = 1'b1;
      #1;
      check("clear_blocks_ready", int'(bus.in_ready), 0);
      @(negedge clk); clear = 1'b0; bus.in_valid = 1'b0; model_clear();
      repeat (3) begin @(negedge clk); check("clear_no_accept", int'(bus.out_valid), 0); end
      node(1, 6, 2, 0, 0, el);
      // clear while in flight: table wiped, in-flight entry still written
      node(0, 0, 0, 0, 5, el);
      issue(1, 8, 0, 0, 0, el);
      clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      model_clear(); mvalid[8] = 1'b1;
      collect();
      node(1, 9, 8, 0, 0, el);
      check("pin_inflight_kept", int'(exp_err), 0);
      node(1, 10, 0, 0, 0, el);

      // 6: async reset while in CALC drops the result and the table
      node(0, 5, 0, 0, 4, el);
      issue(1, 7, 5, 0, 0, el);
      rst_n = 1'b0; exp_pending = 1'b0; model_clear();
      #1;
      check("rst_mid_out_valid", int'(bus.out_valid), 0);
      check("rst_mid_in_ready", int'(bus.in_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); check("rst_no_pulse", int'(bus.out_valid), 0); end
      node(1, 7, 5, 0, 0, el);
      check("pin_rst_err", int'(exp_err), 1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends with a summary
   initial begin
      #200000;
      check("global_timeout", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
